// File: rtl/stage_ctrl_decoder_if.sv
// Control AXI-Stream bundle (no tready) shared by the input and forwarded
// ports of stage_ctrl_decoder.
interface stage_ctrl_decoder_if #(
  parameter int DATA_W = 256,
  parameter int USER_W = 128
);
  logic [DATA_W-1:0]   tdata;
  logic [USER_W-1:0]   tuser;
  logic [DATA_W/8-1:0] tkeep;
  logic                tvalid;
  logic                tlast;

  modport master (output tdata, tuser, tkeep, tvalid, tlast);
  modport slave  (input  tdata, tuser, tkeep, tvalid, tlast);
endinterface

// File: rtl/stage_ctrl_decoder.sv
// stage_ctrl_decoder: consumes control packets addressed to STAGE_ID and
// turns each one into a single write pulse for the key-offset RAM, lookup
// CAM or action RAM. Packets for other stages are forwarded one cycle later.
// Optional feature: define STAGE_CTRL_ERR_CNT_EN to count malformed packets
// in err_cnt; without it err_cnt is tied to 0.
module stage_ctrl_decoder #(
  parameter int STAGE_ID             = 0,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
  input  logic                               clk,
  input  logic                               rst,
  stage_ctrl_decoder_if.slave                c_s_axis,
  stage_ctrl_decoder_if.master               c_m_axis,
  output logic [2:0]                         cfg_wr_sel,
  output logic [7:0]                         cfg_wr_addr,
  output logic [3*C_S_AXIS_DATA_WIDTH-1:0]   cfg_wr_data,
  output logic [15:0]                        err_cnt
);
  localparam int W  = C_S_AXIS_DATA_WIDTH;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;
  localparam int KW = W / 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FWD     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_DROP    = 2'd3;

  localparam logic [4:0] MY_STAGE = 5'(STAGE_ID);

  // Header fields, meaningful only on the first beat of a packet.
  logic [4:0] hdr_stage;
  logic [2:0] hdr_res;
  logic [7:0] hdr_idx;
  logic       hdr_own;
  logic       hdr_res_ok;

  assign hdr_stage  = c_s_axis.tdata[15:11];
  assign hdr_res    = c_s_axis.tdata[10:8];
  assign hdr_idx    = c_s_axis.tdata[7:0];
  assign hdr_own    = (hdr_stage == MY_STAGE);
  assign hdr_res_ok = (hdr_res <= 3'd2);

  logic [1:0]     state_q, state_d;
  logic [1:0]     beat_cnt_q, beat_cnt_d;
  logic [2*W-1:0] pay_q, pay_d;
  logic [7:0]     idx_q, idx_d;
  logic [1:0]     res_q, res_d;

  logic [W-1:0]   m_tdata_q, m_tdata_d;
  logic [UW-1:0]  m_tuser_q, m_tuser_d;
  logic [KW-1:0]  m_tkeep_q, m_tkeep_d;
  logic           m_tvalid_q, m_tvalid_d;
  logic           m_tlast_q, m_tlast_d;
  logic [2:0]     wr_sel_q, wr_sel_d;
  logic [7:0]     wr_addr_q, wr_addr_d;
  logic [3*W-1:0] wr_data_q, wr_data_d;

  logic           fwd;
  logic           wr;
  logic           err_inc;
  logic           beat_ovf;
  logic [3*W-1:0] merged;

  // Three payload beats already seen: the current one is the overflow beat.
  assign beat_ovf = (beat_cnt_q == 2'd3);

  // Stored payload with the current beat dropped into its slot; the write
  // data when this beat closes the packet.
  always_comb begin
    merged = {{W{1'b0}}, pay_q};
    case (beat_cnt_q)
      2'd0:    merged[W-1:0]     = c_s_axis.tdata;
      2'd1:    merged[2*W-1:W]   = c_s_axis.tdata;
      2'd2:    merged[3*W-1:2*W] = c_s_axis.tdata;
      default: merged            = {{W{1'b0}}, pay_q};
    endcase
  end

  // Packet decode FSM: classifies headers, collects payload, flags errors.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and infers a latch.
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    pay_d      = pay_q;
    idx_d      = idx_q;
    res_d      = res_q;
    fwd        = 1'b0;
    wr         = 1'b0;
    err_inc    = 1'b0;
    if (c_s_axis.tvalid) begin
      case (state_q)
        ST_IDLE: begin
          if (!hdr_own) begin
            fwd = 1'b1;
            if (!c_s_axis.tlast) state_d = ST_FWD;
          end else if (hdr_res_ok && !c_s_axis.tlast) begin
            state_d    = ST_PAYLOAD;
            beat_cnt_d = 2'd0;
            pay_d      = '0;
            idx_d      = hdr_idx;
            res_d      = hdr_res[1:0];
          end else begin
            err_inc = 1'b1;
            if (!c_s_axis.tlast) state_d = ST_DROP;
          end
        end
        ST_FWD: begin
          fwd = 1'b1;
          if (c_s_axis.tlast) state_d = ST_IDLE;
        end
        ST_PAYLOAD: begin
          if (beat_ovf) begin
            err_inc = 1'b1;
            state_d = c_s_axis.tlast ? ST_IDLE : ST_DROP;
          end else if (c_s_axis.tlast) begin
            wr      = 1'b1;
            state_d = ST_IDLE;
          end else begin
            pay_d      = merged[2*W-1:0];
            beat_cnt_d = beat_cnt_q + 2'd1;
          end
        end
        default: begin
          if (c_s_axis.tlast) state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Next values of the registered forward stream and write port.
  always_comb begin
    m_tvalid_d = fwd;
    m_tlast_d  = fwd & c_s_axis.tlast;
    m_tdata_d  = fwd ? c_s_axis.tdata : m_tdata_q;
    m_tuser_d  = fwd ? c_s_axis.tuser : m_tuser_q;
    m_tkeep_d  = fwd ? c_s_axis.tkeep : m_tkeep_q;
    wr_sel_d   = wr ? (3'b001 << res_q) : 3'b000;
    wr_addr_d  = wr ? idx_q : wr_addr_q;
    wr_data_d  = wr ? merged : wr_data_q;
  end

  // State and output registers; everything clears on reset, including the
  // payload slots, so a reset mid-packet leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= 2'd0;
      pay_q      <= '0;
      idx_q      <= '0;
      res_q      <= '0;
      m_tdata_q  <= '0;
      m_tuser_q  <= '0;
      m_tkeep_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      wr_sel_q   <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      pay_q      <= pay_d;
      idx_q      <= idx_d;
      res_q      <= res_d;
      m_tdata_q  <= m_tdata_d;
      m_tuser_q  <= m_tuser_d;
      m_tkeep_q  <= m_tkeep_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      wr_sel_q   <= wr_sel_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

`ifdef STAGE_CTRL_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating count of malformed own-stage packets.
  always_comb begin
    err_cnt_d = (err_inc && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;
  end

  // Error counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_err_inc;
  assign unused_err_inc = err_inc;
  assign err_cnt        = '0;
`endif

  assign c_m_axis.tdata  = m_tdata_q;
  assign c_m_axis.tuser  = m_tuser_q;
  assign c_m_axis.tkeep  = m_tkeep_q;
  assign c_m_axis.tvalid = m_tvalid_q;
  assign c_m_axis.tlast  = m_tlast_q;
  assign cfg_wr_sel      = wr_sel_q;
  assign cfg_wr_addr     = wr_addr_q;
  assign cfg_wr_data     = wr_data_q;
endmodule
